ifmap_spad_ctrl: RTL and testbench

//  Sequencer on the port side of ifmap_spad (clk/addr/we/bidirectional data_port).

---
 rtl/ifmap_spad_ctrl.sv | 159 +++++++++++++++
 tb/tb_ifmap_spad_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_spad_ctrl.sv
// ifmap_spad_ctrl: port-side sequencer for ifmap_spad.
// Fills the spad from a valid/ready stream, then drains the burst back in address
// order to the PE MAC, repeating the whole burst cfg_reuse times.
//
// state | meaning
// IDLE  | waiting for start; a zero-length job pulses done without leaving IDLE
// FILL  | writing accepted stream words to spad[wr_ptr]
// TURN  | one dead cycle so the write driver releases the bus before reads
// DRAIN | reading spad[rd_ptr] into the output register, pass after pass
module ifmap_spad_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [3:0]        cfg_reuse,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  inout  wire  [DATA_W-1:0] spad_data
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_TURN, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [3:0]        reuse_q, reuse_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]        pass_q, pass_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;

  logic [ADDR_W:0] len_m1;
  logic            wr_at_end, rd_at_end, pass_at_end;
  logic            fill_acc, drain_load;

  assign len_m1      = len_q - 1'b1;
  assign wr_at_end   = ({1'b0, wr_ptr_q} == len_m1);
  assign rd_at_end   = ({1'b0, rd_ptr_q} == len_m1);
  assign pass_at_end = (pass_q == reuse_q - 4'd1);
  assign fill_acc    = (state_q == S_FILL) && in_valid;
  // Once the final word sits in the output register nothing more is loaded.
  assign drain_load  = (state_q == S_DRAIN) && (!out_valid_q || out_ready) && !out_last_q;

  assign in_ready  = (state_q == S_FILL);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign spad_we   = fill_acc;
  assign spad_addr = (state_q == S_FILL)  ? wr_ptr_q :
                     (state_q == S_DRAIN) ? rd_ptr_q : '0;
  assign spad_data = spad_we ? in_data : {DATA_W{1'bz}};

  // Next-state and datapath updates for the fill/turn/drain sequence.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    reuse_d     = reuse_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pass_d      = pass_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse belongs to the finished job.
        if (start && !done_q) begin
          len_d    = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
          reuse_d  = (cfg_reuse == 4'd0) ? 4'd1 : cfg_reuse;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          pass_d   = '0;
          if (cfg_len == '0) done_d = 1'b1;
          else               state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_acc) begin
          if (wr_at_end) begin
            wr_ptr_d = '0;
            state_d  = S_TURN;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_TURN: state_d = S_DRAIN;
      S_DRAIN: begin
        if (drain_load) begin
          out_data_d  = spad_data;
          out_valid_d = 1'b1;
          out_last_d  = rd_at_end && pass_at_end;
          if (rd_at_end) begin
            rd_ptr_d = '0;
            pass_d   = pass_q + 4'd1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset to the idle/quiet values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      reuse_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pass_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      reuse_q     <= reuse_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pass_q      <= pass_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Bench for ifmap_spad_ctrl: stimulus pushes expected writes/beats into queues,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_ifmap_spad_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  cfg_len;
  logic [3:0]  cfg_reuse;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [3:0]  spad_addr;
  logic        spad_we;
  wire  [15:0] spad_data;

  ifmap_spad_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_reuse(cfg_reuse),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .spad_addr(spad_addr), .spad_we(spad_we), .spad_data(spad_data)
  );

  always #5 clk = ~clk;

  // Bench model of the spad: async read onto the shared bus, write on posedge.
  logic [15:0] mem [16];
  assign spad_data = spad_we ? 16'bz : mem[spad_addr];
  always @(posedge clk) if (spad_we) mem[spad_addr] <= spad_data;

  logic [16:0] exp_out [$];
  logic [19:0] exp_wr  [$];
  logic [15:0] wbuf [16];
  int  n_chk = 0;
  int  n_pass = 0;
  int  done_seen = 0;
  bit  job_active = 0;
  bit  fill_phase = 0;
  bit  ready_toggle = 0;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_toggle) out_ready = ~out_ready;
      else out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every write and every drain handshake.
  initial begin
    int cyc = 0;
    int last_wr_cyc = 0;
    bit prev_stall = 0, prev_valid = 0, prev_last_hs = 0, prev_zero = 0;
    logic [15:0] prev_data = '0;
    logic [19:0] ew;
    logic [16:0] eo;
    bit exp_done;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 0; prev_valid = 0; prev_last_hs = 0; prev_zero = 0;
      end else begin
        if (spad_we) begin
          chk("wr_pending", exp_wr.size() != 0, exp_wr.size(), 1);
          if (exp_wr.size() != 0) begin
            ew = exp_wr.pop_front();
            chk("wr", {spad_addr, spad_data} == ew, {spad_addr, spad_data}, ew);
          end
          last_wr_cyc = cyc;
        end
        if (fill_phase && !in_valid) chk("we_gap", spad_we == 1'b0, spad_we, 0);
        if (job_active && !spad_we) chk("bus_release", spad_data === mem[spad_addr], spad_data, mem[spad_addr]);
        if (prev_stall) chk("stall_hold", {out_valid, out_data} == {1'b1, prev_data}, {out_valid, out_data}, {1'b1, prev_data});
        if (out_valid && !prev_valid) chk("turn_latency", (cyc - last_wr_cyc) == 3, cyc - last_wr_cyc, 3);
        if (out_valid && out_ready) begin
          chk("out_pending", exp_out.size() != 0, exp_out.size(), 1);
          if (exp_out.size() != 0) begin
            eo = exp_out.pop_front();
            chk("out_beat", {out_last, out_data} == eo, {out_last, out_data}, eo);
          end
        end
        exp_done = prev_last_hs || prev_zero;
        if (done || exp_done) chk("done_timing", done == exp_done, done, exp_done);
        if (done) done_seen++;
        prev_stall   = out_valid && !out_ready;
        prev_data    = out_data;
        prev_valid   = out_valid;
        prev_last_hs = out_valid && out_ready && out_last;
        prev_zero    = start && (cfg_len == 5'd0) && !job_active;
      end
    end
  end

  task automatic run_job(input int len_cfg, input int reuse_cfg, input bit gaps,
                         input bit inject, input int abort_at);
    int el, er, d0;
    bit ok;
    el = (len_cfg > 16) ? 16 : len_cfg;
    er = (reuse_cfg == 0) ? 1 : reuse_cfg;
    d0 = done_seen;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 5'(len_cfg); cfg_reuse = 4'(reuse_cfg);
    if (el > 0) job_active = 1;
    if (abort_at == 0)
      for (int p = 0; p < er; p++)
        for (int i = 0; i < el; i++)
          exp_out.push_back({(p == er-1) && (i == el-1), wbuf[i]});
    @(posedge clk); #1;
    start = 1'b0;
    if (el == 0) begin
      repeat (3) begin
        @(negedge clk);
        chk("busy_len0", busy == 1'b0, busy, 0);
      end
      chk("len0_done", done_seen == d0 + 1, done_seen - d0, 1);
      return;
    end
    fill_phase = 1;
    for (int i = 0; i < el; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_outputs", {in_ready, out_valid, out_last, busy, done, spad_we, spad_addr, out_data} == 26'd0,
            {in_ready, out_valid, out_last, busy, done, spad_we, spad_addr, out_data}, 0);
        exp_out.delete();
        chk("rst_wr_drained", exp_wr.size() == 0, exp_wr.size(), 0);
        exp_wr.delete();
        in_valid = 1'b0; in_data = 16'hFFFF;
        fill_phase = 0; job_active = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = wbuf[i];
      exp_wr.push_back({4'(i), wbuf[i]});
      ok = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      chk("in_ready", ok, ok, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = 16'hFFFF;
    fill_phase = 0;
    if (inject) begin
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; cfg_len = 5'd3; cfg_reuse = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
    end
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk("job_done", ok, ok, 1);
    job_active = 0;
    chk("sb_empty", (exp_out.size() + exp_wr.size()) == 0, exp_out.size() + exp_wr.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_reuse = '0;
    in_valid = 1'b0; in_data = 16'hFFFF; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, out_valid, out_last, busy, done, spad_we, spad_addr, out_data} == 26'd0,
        {in_ready, out_valid, out_last, busy, done, spad_we, spad_addr, out_data}, 0);
    rst = 1'b0;

    // full-depth burst, single pass
    for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
    run_job(16, 1, 0, 0, 0);

    // short burst reused three times
    for (int i = 0; i < 5; i++) wbuf[i] = 16'(16'h0011 * (i + 1));
    run_job(5, 3, 0, 0, 0);

    // fill gaps and a stalling consumer
    for (int i = 0; i < 6; i++) wbuf[i] = 16'(16'hA000 + 16'h0101 * i);
    ready_toggle = 1;
    run_job(6, 2, 1, 0, 0);
    ready_toggle = 0;

    // zero length, over-length clamp, zero reuse
    run_job(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) wbuf[i] = 16'(16'h5000 + i);
    run_job(20, 0, 0, 0, 0);

    // reset in the middle of a fill, then a fresh short job
    for (int i = 0; i < 16; i++) wbuf[i] = 16'(16'hC000 + i);
    run_job(16, 1, 0, 0, 7);
    wbuf[0] = 16'h1234; wbuf[1] = 16'h5678; wbuf[2] = 16'h9ABC; wbuf[3] = 16'hDEF0;
    run_job(4, 1, 0, 0, 0);

    // start pulsed during drain must not disturb the running job
    for (int i = 0; i < 8; i++) wbuf[i] = 16'(16'h0F00 + 16'h0011 * i);
    ready_toggle = 1;
    run_job(8, 2, 0, 1, 0);
    ready_toggle = 0;
    repeat (4) @(negedge clk);
    chk("idle_after_inject", busy == 1'b0, busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
